fp_operand_serializer: RTL and testbench

//  Upstream feeder for the four-operand serial FP adder. Accepts parallel operands a/b/c/d (IEEE-754 single)

---
 rtl/fp_serial_pkg.sv | 23 ++
 rtl/fp_operand_fifo.sv | 105 ++++++++++
 rtl/fp_operand_serializer.sv | 149 ++++++++++++++
 tb/tb_fp_operand_serializer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_serial_pkg.sv
// rtl/fp_serial_pkg.sv - shared frame constants, operand bundle type and FSM states for the serial FP adder links
package fp_serial_pkg;

    localparam int WORD_W      = 32;
    localparam int SETUP_W     = 8;
    localparam int SETUP_START = 24;
    localparam int CNT_W       = $clog2(WORD_W);

    typedef struct packed {
        logic [WORD_W-1:0]  a;
        logic [WORD_W-1:0]  b;
        logic [WORD_W-1:0]  c;
        logic [WORD_W-1:0]  d;
        logic [SETUP_W-1:0] setup;
    } fp_frame_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } fsm_t;

endpackage

// File: rtl/fp_operand_fifo.sv
// rtl/fp_operand_fifo.sv - operand request buffer; DEPTH-entry circular FIFO with FPSER_FIFO_EN, else one holding register
module fp_operand_fifo
    import fp_serial_pkg::*;
#(
`ifdef FPSER_FIFO_EN
    parameter int DEPTH = 2
`endif
) (
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      push_in,
    input  fp_frame_t push_data_in,
    output logic      ready_out,
    input  logic      pop_in,
    output fp_frame_t head_out,
    output logic      empty_out
);

`ifdef FPSER_FIFO_EN
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W2 = $clog2(DEPTH + 1);

    fp_frame_t           mem_q [DEPTH];
    fp_frame_t           mem_d [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W2-1:0]   count_q, count_d;
    logic                push_ok;
    logic                pop_ok;

    // ready depends on the registered count only, so a same-cycle pop never frees a slot early
    assign ready_out = (count_q < CNT_W2'(DEPTH));
    assign empty_out = (count_q == '0);
    assign head_out  = mem_q[rd_ptr_q];
    assign push_ok   = push_in && ready_out;
    assign pop_ok    = pop_in && !empty_out;

    // next-state for storage, wrapping pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data_in;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W2'(1);
            2'b01:   count_d = count_q - CNT_W2'(1);
            default: count_d = count_q;
        endcase
    end

    // register FIFO state
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
`else
    fp_frame_t hold_q, hold_d;
    logic      full_q, full_d;

    // a single slot: refuse new requests from accept until the shifter takes the entry
    assign ready_out = !full_q;
    assign empty_out = !full_q;
    assign head_out  = hold_q;

    // next-state for the holding register
    always_comb begin
        hold_d = hold_q;
        full_d = full_q;
        if (pop_in && full_q) begin
            full_d = 1'b0;
        end else if (push_in && !full_q) begin
            hold_d = push_data_in;
            full_d = 1'b1;
        end
    end

    // register holding state
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hold_q <= '0;
            full_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            full_q <= full_d;
        end
    end
`endif

endmodule

// File: rtl/fp_operand_serializer.sv
// rtl/fp_operand_serializer.sv - parallel-to-serial operand feeder for the four-operand serial FP adder (FPSER_FIFO_EN selects queued buffer)
module fp_operand_serializer
    import fp_serial_pkg::*;
#(
`ifdef FPSER_FIFO_EN
    parameter int DEPTH = 2,
`endif
    parameter int GAP = 3
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [WORD_W-1:0] a_in,
    input  logic [WORD_W-1:0] b_in,
    input  logic [WORD_W-1:0] c_in,
    input  logic [WORD_W-1:0] d_in,
    input  logic [SETUP_W-1:0] setup_in,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic              adder_rdy_in,
    output logic              serial1_out,
    output logic              serial2_out,
    output logic              serial3_out,
    output logic              serial4_out,
    output logic              wr_out,
    output logic              setup_serial_out,
    output logic              busy_out
);

    fp_frame_t push_data;
    fp_frame_t head;
    logic      fifo_empty;
    logic      pop;

    fsm_t                     state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [3:0][WORD_W-1:0]   sh_q, sh_d;
    logic [SETUP_W-1:0]       setup_sh_q, setup_sh_d;
    logic [3:0]               ser_q, ser_d;
    logic                     wr_q, wr_d;
    logic                     setup_out_q, setup_out_d;

    assign push_data = '{a: a_in, b: b_in, c: c_in, d: d_in, setup: setup_in};

    fp_operand_fifo
`ifdef FPSER_FIFO_EN
        #(.DEPTH(DEPTH))
`endif
    u_fifo (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .push_in      (valid_in),
        .push_data_in (push_data),
        .ready_out    (ready_out),
        .pop_in       (pop),
        .head_out     (head),
        .empty_out    (fifo_empty)
    );

    // frame sequencing: the pop edge already presents bit 0, so outputs lead the shift registers by one bit
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        setup_sh_d  = setup_sh_q;
        ser_d       = '0;
        wr_d        = 1'b0;
        setup_out_d = 1'b0;
        pop         = 1'b0;
        case (state_q)
            fp_serial_pkg::IDLE: begin
                if (!fifo_empty && adder_rdy_in) begin
                    pop        = 1'b1;
                    state_d    = fp_serial_pkg::SHIFT;
                    cnt_d      = '0;
                    wr_d       = 1'b1;
                    setup_sh_d = head.setup;
                    sh_d[3]    = head.a;
                    sh_d[2]    = head.b;
                    sh_d[1]    = head.c;
                    sh_d[0]    = head.d;
                    for (int i = 0; i < 4; i++) begin
                        ser_d[i] = sh_d[i][0];
                        sh_d[i]  = sh_d[i] >> 1;
                    end
                end
            end
            fp_serial_pkg::SHIFT: begin
                if (cnt_q == CNT_W'(WORD_W - 1)) begin
                    state_d = fp_serial_pkg::GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    wr_d  = 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        ser_d[i] = sh_q[i][0];
                        sh_d[i]  = sh_q[i] >> 1;
                    end
                    if (cnt_d >= CNT_W'(SETUP_START)) begin
                        setup_out_d = setup_sh_q[0];
                        setup_sh_d  = setup_sh_q >> 1;
                    end
                end
            end
            fp_serial_pkg::GAP: begin
                if (cnt_q == CNT_W'(GAP - 1)) begin
                    state_d = fp_serial_pkg::IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = fp_serial_pkg::IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM, counter, shift registers and registered frame outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= fp_serial_pkg::IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            setup_sh_q  <= '0;
            ser_q       <= '0;
            wr_q        <= 1'b0;
            setup_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            setup_sh_q  <= setup_sh_d;
            ser_q       <= ser_d;
            wr_q        <= wr_d;
            setup_out_q <= setup_out_d;
        end
    end

    // serial1..4 carry d, c, b, a
    assign serial1_out      = ser_q[0];
    assign serial2_out      = ser_q[1];
    assign serial3_out      = ser_q[2];
    assign serial4_out      = ser_q[3];
    assign wr_out           = wr_q;
    assign setup_serial_out = setup_out_q;
    assign busy_out         = !fifo_empty || (state_q != fp_serial_pkg::IDLE);

endmodule

// File: tb/tb_fp_operand_serializer.sv
// tb/tb_fp_operand_serializer.sv - directed self-checking bench for fp_operand_serializer
module tb_fp_operand_serializer;

`ifdef FPSER_FIFO_EN
    localparam bit MULTI = 1'b1;
`else
    localparam bit MULTI = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] a_in = '0, b_in = '0, c_in = '0, d_in = '0;
    logic [7:0]  setup_in = '0;
    logic        valid_in = 1'b0;
    logic        adder_rdy_in = 1'b0;
    logic        ready_out, serial1_out, serial2_out, serial3_out, serial4_out;
    logic        wr_out, setup_serial_out, busy_out;

    int          total = 0;
    int          passes = 0;
    int          fails = 0;
    logic [31:0] s1, s2, s3, s4, st;
    int          wrn, gapn, hi;

    always #5 clk_in = ~clk_in;

    fp_operand_serializer dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .a_in             (a_in),
        .b_in             (b_in),
        .c_in             (c_in),
        .d_in             (d_in),
        .setup_in         (setup_in),
        .valid_in         (valid_in),
        .ready_out        (ready_out),
        .adder_rdy_in     (adder_rdy_in),
        .serial1_out      (serial1_out),
        .serial2_out      (serial2_out),
        .serial3_out      (serial3_out),
        .serial4_out      (serial4_out),
        .wr_out           (wr_out),
        .setup_serial_out (setup_serial_out),
        .busy_out         (busy_out)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input logic [31:0] d, input logic [7:0] s);
        a_in = a; b_in = b; c_in = c; d_in = d; setup_in = s;
    endtask

    // called at frame cycle 0; leaves the bench at the first cycle after the frame
    task automatic capture();
        s1 = '0; s2 = '0; s3 = '0; s4 = '0; st = '0; wrn = 0;
        for (int i = 0; i < 32; i++) begin
            s1[i] = serial1_out;
            s2[i] = serial2_out;
            s3[i] = serial3_out;
            s4[i] = serial4_out;
            st[i] = setup_serial_out;
            if (wr_out) wrn++;
            tick();
        end
    endtask

    task automatic wait_wr(input int limit);
        gapn = 0;
        while (wr_out !== 1'b1 && gapn < limit) begin
            gapn++;
            tick();
        end
        chk1("wr_timeout", wr_out, 1'b1);
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk1("rst_wr", wr_out, 1'b0);
        chk("rst_serial", {28'd0, serial4_out, serial3_out, serial2_out, serial1_out}, 32'd0);
        chk1("rst_setup", setup_serial_out, 1'b0);
        chk1("rst_ready", ready_out, 1'b1);
        chk1("rst_busy", busy_out, 1'b0);
        rst_in = 1'b0;
        adder_rdy_in = 1'b1;
        tick();

        // 1: 1.0 on every lane, setup 0x1E, two-cycle latency
        set_op(32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h3f800000, 8'h1E);
        valid_in = 1'b1;
        chk1("t1_ready", ready_out, 1'b1);
        tick();
        valid_in = 1'b0;
        chk1("t1_lat1_wr", wr_out, 1'b0);
        chk1("t1_lat1_busy", busy_out, 1'b1);
        tick();
        chk1("t1_lat2_wr", wr_out, 1'b1);
        capture();
        chk("t1_s4", s4, 32'h3f800000);
        chk("t1_s1", s1, 32'h3f800000);
        chk("t1_s2", s2, 32'h3f800000);
        chk("t1_setup", st, 32'h1E000000);
        chk("t1_wrlen", 32'(wrn), 32'd32);
        chk1("t1_wr_after", wr_out, 1'b0);
        repeat (6) tick();
        chk1("t1_idle_busy", busy_out, 1'b0);

        // 2: only a carries bits
        set_op(32'hbf800001, 32'h0, 32'h0, 32'h0, 8'h00);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        capture();
        chk("t2_s4", s4, 32'hbf800001);
        chk1("t2_s4_bit0", s4[0], 1'b1);
        chk("t2_s3", s3, 32'h0);
        chk("t2_s2", s2, 32'h0);
        chk("t2_s1", s1, 32'h0);
        chk("t2_setup", st, 32'h0);
        repeat (6) tick();

        // 4: adder not ready holds the queued entry
        adder_rdy_in = 1'b0;
        set_op(32'h12345678, 32'h9abcdef0, 32'h0f0f0f0f, 32'h80000001, 8'hA5);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        repeat (5) tick();
        chk1("t4_hold_wr", wr_out, 1'b0);
        chk1("t4_hold_busy", busy_out, 1'b1);
        chk1("t4_hold_ready", ready_out, MULTI);
        adder_rdy_in = 1'b1;
        chk1("t4_pre_wr", wr_out, 1'b0);
        tick();
        chk1("t4_start_wr", wr_out, 1'b1);
        capture();
        chk("t4_s4", s4, 32'h12345678);
        chk("t4_s3", s3, 32'h9abcdef0);
        chk("t4_s2", s2, 32'h0f0f0f0f);
        chk("t4_s1", s1, 32'h80000001);
        chk("t4_setup", st, 32'hA5000000);
        repeat (6) tick();

        // 3: back-to-back requests, refused push while full, ordered frames with a 4-cycle gap
        adder_rdy_in = 1'b0;
        set_op(32'hA0000001, 32'h0, 32'h0, 32'h0000000A, 8'h01);
        valid_in = 1'b1;
        tick();
`ifdef FPSER_FIFO_EN
        set_op(32'hB0000002, 32'h0, 32'h0, 32'h0000000B, 8'h02);
        chk1("t3_ready_b", ready_out, 1'b1);
        tick();
`endif
        set_op(32'hC0000003, 32'h0, 32'h0, 32'h0000000C, 8'h03);
        chk1("t3_full_ready", ready_out, 1'b0);
        tick();
        chk1("t3_still_full", ready_out, 1'b0);
        adder_rdy_in = 1'b1;
        tick();
        chk1("t3_pop_wr", wr_out, 1'b1);
        chk1("t3_pop_ready", ready_out, 1'b1);
        capture();
        valid_in = 1'b0;
        chk("t3_f1_s4", s4, 32'hA0000001);
        chk("t3_f1_s1", s1, 32'h0000000A);
        wait_wr(20);
        chk("t3_gap1", 32'(gapn), 32'd4);
`ifdef FPSER_FIFO_EN
        capture();
        chk("t3_f2_s4", s4, 32'hB0000002);
        chk("t3_f2_setup", st, 32'h02000000);
        wait_wr(20);
        chk("t3_gap2", 32'(gapn), 32'd4);
`endif
        capture();
        chk("t3_f3_s4", s4, 32'hC0000003);
        chk("t3_f3_s1", s1, 32'h0000000C);
        repeat (6) tick();
        chk1("t3_idle_busy", busy_out, 1'b0);

        // 5: reset at frame cycle 10 abandons the frame
        set_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'hFF);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        repeat (10) tick();
        chk1("t5_pre_wr", wr_out, 1'b1);
        chk1("t5_pre_s4", serial4_out, 1'b1);
        rst_in = 1'b1;
        #1;
        chk1("t5_rst_wr", wr_out, 1'b0);
        chk("t5_rst_serial", {28'd0, serial4_out, serial3_out, serial2_out, serial1_out}, 32'd0);
        chk1("t5_rst_ready", ready_out, 1'b1);
        chk1("t5_rst_busy", busy_out, 1'b0);
        #1;
        rst_in = 1'b0;
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (wr_out) hi++;
        end
        chk("t5_no_resume", 32'(hi), 32'd0);
        chk1("t5_idle_busy", busy_out, 1'b0);

        // 6: single request with ready tracking
        adder_rdy_in = 1'b0;
        set_op(32'hc1200000, 32'h0, 32'h0, 32'h0, 8'hBE);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        chk1("t6_ready_held", ready_out, MULTI);
        tick();
        tick();
        chk1("t6_ready_held2", ready_out, MULTI);
        adder_rdy_in = 1'b1;
        tick();
        chk1("t6_wr", wr_out, 1'b1);
        chk1("t6_ready_pop", ready_out, 1'b1);
        capture();
        chk("t6_s4", s4, 32'hc1200000);
        chk("t6_s1", s1, 32'h0);
        chk("t6_setup", st, 32'hBE000000);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
